// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and payload types for the register-file write scheduler.
package rf_pkg;
    localparam int RF_DATA_W = 16;
    localparam int RF_SEL_W = 3;
    typedef struct packed {
        logic [RF_SEL_W-1:0]  sel;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;
    typedef logic req_id_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: power-of-2 FIFO with wrap-bit pointers; push2_i adds a second entry in the same cycle.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type payload_t = rf_wr_t
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  logic     push2_i,
    input  payload_t din_i,
    input  payload_t din2_i,
    input  logic     pop_i,
    output payload_t dout_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);
    payload_t mem_q [DEPTH];
    logic [AW:0] wp_q, rp_q, wp_d, rp_d, wp1;
    assign wp1 = wp_q + (AW+1)'(1);
    assign wp_d = wp_q + (AW+1)'(push_i) + (AW+1)'(push_i && push2_i);
    assign rp_d = rp_q + (AW+1)'(pop_i);
    assign dout_o = mem_q[rp_q[AW-1:0]];
    assign empty_o = wp_q == rp_q;
    assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q[AW-1:0]] <= din_i;
        if (push_i && push2_i) mem_q[wp1[AW-1:0]] <= din2_i;
    end
endmodule

// File: rtl/rf_wr_sched.sv
// rf_wr_sched: two-requester write-port scheduler issuing writes in acceptance order.
// Optional RF_WR_PEND_EN adds pend_mask, a per-register pending-write bitmap.
module rf_wr_sched
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int SEL_W = RF_SEL_W,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_writeEn,
    output logic [SEL_W-1:0]  rf_writeRegSel,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              busy,
    output logic              err
`ifdef RF_WR_PEND_EN
    ,
    output logic [2**SEL_W-1:0] pend_mask
`endif
);
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_t;
    logic acc0, acc1, dual, same, issue;
    logic full0, full1, empty0, empty1, oq_full, oq_empty;
    logic rr_q, stall0_q, stall1_q, viol0, viol1;
    wr_t in0, in1, head0, head1, head, last_q, prev0_q, prev1_q;
    req_id_t first, oq_head;
    assign in0 = wr_t'{req0_sel, req0_data};
    assign in1 = wr_t'{req1_sel, req1_data};
    assign req0_ready = !full0;
    assign req1_ready = !full1;
    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;
    assign dual = acc0 && acc1;
    assign same = req0_sel == req1_sel;
    // Same-register pairs always let req1 land last; otherwise alternate fairly.
    assign first = dual ? (same ? 1'b0 : rr_q) : acc1;
    assign issue = !oq_empty && !rst;
    assign head = oq_head ? head1 : head0;
    assign rf_writeEn = issue;
    assign rf_writeRegSel = issue ? head.sel : last_q.sel;
    assign rf_writeData = issue ? head.data : last_q.data;
    assign busy = !oq_empty;
    assign viol0 = stall0_q && (!req0_valid || in0 != prev0_q);
    assign viol1 = stall1_q && (!req1_valid || in1 != prev1_q);
    rf_wr_fifo #(.DEPTH(QDEPTH), .payload_t(wr_t)) u_fifo0 (
        .clk(clk), .rst(rst), .push_i(acc0), .push2_i(1'b0), .din_i(in0), .din2_i('0),
        .pop_i(issue && !oq_head), .dout_o(head0), .full_o(full0), .empty_o(empty0)
    );
    rf_wr_fifo #(.DEPTH(QDEPTH), .payload_t(wr_t)) u_fifo1 (
        .clk(clk), .rst(rst), .push_i(acc1), .push2_i(1'b0), .din_i(in1), .din2_i('0),
        .pop_i(issue && oq_head), .dout_o(head1), .full_o(full1), .empty_o(empty1)
    );
    rf_wr_fifo #(.DEPTH(2*QDEPTH), .payload_t(req_id_t)) u_order (
        .clk(clk), .rst(rst), .push_i(acc0 || acc1), .push2_i(dual), .din_i(first),
        .din2_i(req_id_t'(!first)), .pop_i(issue), .dout_o(oq_head), .full_o(oq_full),
        .empty_o(oq_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
            err <= 1'b0;
            last_q <= '0;
            stall0_q <= 1'b0;
            stall1_q <= 1'b0;
            prev0_q <= '0;
            prev1_q <= '0;
        end else begin
            if (dual && !same) rr_q <= !rr_q;
            if (issue) last_q <= head;
            err <= err || viol0 || viol1;
            stall0_q <= req0_valid && !req0_ready;
            stall1_q <= req1_valid && !req1_ready;
            prev0_q <= in0;
            prev1_q <= in1;
        end
    end
    // The order queue is sized to the FIFOs combined, and its head always names a non-empty FIFO.
    assert property (@(posedge clk) disable iff (rst)
        !(oq_full && (acc0 || acc1)) && !(issue && (oq_head ? empty1 : empty0)));
`ifdef RF_WR_PEND_EN
    localparam int CW = $clog2(2*QDEPTH+1);
    logic [CW-1:0] cnt_q [2**SEL_W];
    for (genvar r = 0; r < 2**SEL_W; r++) begin : g_pend
        always_ff @(posedge clk) begin
            if (rst) cnt_q[r] <= '0;
            else cnt_q[r] <= cnt_q[r] + CW'(acc0 && req0_sel == SEL_W'(r))
                + CW'(acc1 && req1_sel == SEL_W'(r)) - CW'(issue && head.sel == SEL_W'(r));
        end
        assign pend_mask[r] = cnt_q[r] != '0;
    end
`endif
endmodule

// File: tb/tb_rf_wr_sched.sv
// tb_rf_wr_sched: scoreboard bench; a queue of expected writes in global acceptance order.
module tb_rf_wr_sched;
    localparam int QD = 2;
    logic clk = 0, rst = 1;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [2:0] req0_sel = 0, req1_sel = 0, rf_writeRegSel;
    logic [15:0] req0_data = 0, req1_data = 0, rf_writeData;
    logic rf_writeEn, busy, err;
`ifdef RF_WR_PEND_EN
    logic [7:0] pend_mask;
`endif
    always #5 clk = ~clk;

    rf_wr_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_writeEn(rf_writeEn), .rf_writeRegSel(rf_writeRegSel), .rf_writeData(rf_writeData),
        .busy(busy), .err(err)
`ifdef RF_WR_PEND_EN
        , .pend_mask(pend_mask)
`endif
    );

    typedef struct {
        bit id;
        logic [2:0] sel;
        logic [15:0] data;
    } ent_t;
    ent_t exp_q[$];
    int checks = 0, errors = 0;
    bit rr_m = 0, err_m = 0;
    bit rdy_m[2] = '{1, 1};
    bit v[2] = '{0, 0}, held[2] = '{0, 0}, acc[2] = '{0, 0};
    logic [2:0] s[2] = '{0, 0}, ps[2] = '{0, 0};
    logic [15:0] d[2] = '{0, 0}, pd[2] = '{0, 0};
    logic [15:0] rf_act[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int outstanding(input bit id);
        int c = 0;
        foreach (exp_q[k]) if (exp_q[k].id == id) c++;
        return c;
    endfunction

    // Monitor: FIFO occupancy and the pending bitmap follow from what is still queued.
    initial begin
        ent_t e;
        logic [7:0] pm;
        forever begin
            @(negedge clk);
            rdy_m[0] = outstanding(0) < QD;
            rdy_m[1] = outstanding(1) < QD;
            pm = 0;
            foreach (exp_q[k]) pm[exp_q[k].sel] = 1'b1;
            check("req0_ready", req0_ready, rdy_m[0]);
            check("req1_ready", req1_ready, rdy_m[1]);
            check("busy", busy, exp_q.size() != 0);
            check("rf_writeEn", rf_writeEn, exp_q.size() != 0);
            check("err", err, err_m);
`ifdef RF_WR_PEND_EN
            check("pend_mask", pend_mask, pm);
`endif
            if (rf_writeEn === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_sel", rf_writeRegSel, e.sel);
                check("wr_data", rf_writeData, e.data);
                rf_act[rf_writeRegSel] = rf_writeData;
            end
        end
    end

    task automatic push(input bit n);
        exp_q.push_back(ent_t'{n, s[n], d[n]});
    endtask

    task automatic step();
        for (int n = 0; n < 2; n++) begin
            if (held[n] && (!v[n] || s[n] != ps[n] || d[n] != pd[n])) err_m = 1;
            acc[n] = v[n] && rdy_m[n];
            held[n] = v[n] && !rdy_m[n];
            ps[n] = s[n];
            pd[n] = d[n];
        end
        req0_valid = v[0]; req0_sel = s[0]; req0_data = d[0];
        req1_valid = v[1]; req1_sel = s[1]; req1_data = d[1];
        if (acc[0] && acc[1]) begin
            if (s[0] == s[1]) begin
                push(0);
                push(1);
            end else begin
                push(rr_m);
                push(!rr_m);
                rr_m = !rr_m;
            end
        end else if (acc[0]) push(0);
        else if (acc[1]) push(1);
        @(negedge clk);
        #1;
    endtask

    task automatic rstep(input int p);
        for (int n = 0; n < 2; n++) if (!held[n]) begin
            v[n] = $urandom_range(99) < p;
            s[n] = 3'($urandom_range(7));
            d[n] = 16'($urandom);
        end
        step();
    endtask

    task automatic do_reset(input bit chk_gate);
        rst = 1;
        v = '{0, 0};
        held = '{0, 0};
        req0_valid = 0;
        req1_valid = 0;
        #1;
        if (chk_gate) check("wen_in_rst", rf_writeEn, 1'b0);
        exp_q.delete();
        rr_m = 0;
        err_m = 0;
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s budget expired", name);
    endtask

    initial begin
        int i;
        @(negedge clk);
        #1;
        rst = 0;
        repeat (2) rstep(0);
        // Single write, one-cycle latency.
        v[0] = 1; s[0] = 3; d[0] = 16'h1234;
        step();
        repeat (2) rstep(0);
        // Same register from both requesters: req1 must win.
        v = '{1, 1}; s = '{5, 5}; d = '{16'hAAAA, 16'h5555};
        step();
        repeat (3) rstep(0);
        check("rf_r5", rf_act[5], 16'h5555);
        // req0 streams R0..R3 against a streaming req1 until its FIFO fills.
        i = 0;
        for (int c = 0; c < 40 && i < 4; c++) begin
            v[0] = 1; s[0] = 3'(i); d[0] = 16'h0100 + 16'(i);
            if (!held[1]) begin
                v[1] = 1; s[1] = 3'($urandom_range(7)); d[1] = 16'($urandom);
            end
            step();
            if (acc[0]) i++;
        end
        if (i != 4) bound_fail("r0_stream");
        for (int c = 0; c < 20 && (held[0] || held[1] || exp_q.size() != 0); c++) rstep(0);
        // Protocol violation: change stalled req1 data.
        for (int c = 0; c < 30 && !held[1]; c++) rstep(100);
        if (!held[1]) bound_fail("r1_stall");
        else begin
            d[1] = d[1] ^ 16'h0001;
            step();
        end
        repeat (4) rstep(100);
        do_reset(0);
        repeat (2) rstep(0);
        // Reset with three writes queued.
        v = '{1, 1}; s = '{1, 2}; d = '{16'h0011, 16'h0022};
        step();
        v = '{1, 1}; s = '{3, 4}; d = '{16'h0033, 16'h0044};
        step();
        do_reset(1);
        rstep(0);
        // Pending bitmap for R2/R6.
        v = '{1, 1}; s = '{2, 6}; d = '{16'h0202, 16'h0606};
        step();
        repeat (3) rstep(0);
        // Randomized traffic.
        for (int c = 0; c < 400; c++) rstep(c % 100);
        for (int c = 0; c < 40 && (held[0] || held[1] || exp_q.size() != 0); c++) rstep(0);
        check("drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
